// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: definitions shared by the instruction fetch unit.
//   XLEN          - datapath width (32)
//   EBREAK_INST   - encoding of ebreak; fetch stops after buffering it
//   fetch_state_e - fetch FSM states
//   fetch_entry_t - one instruction buffer entry {pc, data}
package ifu_fetch_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] EBREAK_INST = 32'h0010_0073;

   typedef enum logic [1:0] {
      StReq,
      StWait,
      StHalt
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] data;
   } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous FIFO with flush, used as the fetch instruction buffer.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   flush       - empties the FIFO (wins over push and pop)
//   push        - write push_data; accepted when not full, or when full and popping
//   pop         - remove the head entry; ignored when empty
//   pop_data    - head entry (zero after reset)
//   full, empty - occupancy flags
//   count       - number of stored entries
module ifu_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CW'(DEPTH));
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];

   assign do_pop  = pop && !empty;
   // A full buffer can still take a write when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit with one outstanding memory request and a
// small instruction buffer.
// Ports:
//   clk, rst_n                     - clock, asynchronous active-low reset
//   imem_req_valid/ready/addr      - fetch request channel (word-aligned byte address)
//   imem_rsp_valid/data            - fetch response, always accepted
//   redirect_valid/redirect_pc     - single-cycle PC redirect, flushes the buffer
//   inst_valid/ready/pc/data       - buffered instruction towards decode
//   halted                         - an ebreak was consumed downstream; fetch stopped
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 32'h8000_0000,
   parameter int unsigned     BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst_pc,
   output logic [XLEN-1:0] inst_data,
   output logic            halted
);

   localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            drop_q, drop_d;
   logic            halted_q, halted_d;

   fetch_entry_t    push_entry, head;
   logic            push, pop, flush, req_fire, slot_free;
   logic            fifo_full, fifo_empty;
   logic [CW-1:0]   fifo_count;

   assign slot_free      = (fifo_count != CW'(BUF_DEPTH));
   // rst_n gating keeps the request low while reset is held.
   assign imem_req_valid = rst_n && (state_q == StReq) && slot_free;
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign inst_valid = !fifo_empty;
   assign pop        = inst_valid && inst_ready;
   assign inst_pc    = head.pc;
   assign inst_data  = head.data;
   assign halted     = halted_q;

   assign push_entry = '{pc: pc_q, data: imem_rsp_data};

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      drop_d   = drop_q;
      halted_d = halted_q;
      push     = 1'b0;
      flush    = 1'b0;

      if (redirect_valid) begin
         flush    = 1'b1;
         pc_d     = redirect_pc & ~XLEN'(3);
         halted_d = 1'b0;
         state_d  = StReq;
         drop_d   = 1'b0;
         // Memory still owes a response (pending, or accepted this very cycle):
         // swallow it before issuing the next request.
         if ((state_q == StWait && !imem_rsp_valid) || req_fire) begin
            state_d = StWait;
            drop_d  = 1'b1;
         end
      end else begin
         // The ebreak is always the last buffered entry, so its pop ends fetch.
         if (pop && head.data == EBREAK_INST) begin
            halted_d = 1'b1;
         end
         unique case (state_q)
            StReq: begin
               if (req_fire) begin
                  state_d = StWait;
               end
            end
            StWait: begin
               if (imem_rsp_valid) begin
                  state_d = StReq;
                  if (drop_q) begin
                     drop_d = 1'b0;
                  end else begin
                     push = 1'b1;
                     pc_d = pc_q + XLEN'(4);
                     if (imem_rsp_data == EBREAK_INST) begin
                        state_d = StHalt;
                     end
                  end
               end
            end
            StHalt: begin
               state_d = StHalt;
            end
            default: begin
               state_d = StReq;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StReq;
         pc_q     <= RESET_PC;
         drop_q   <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         drop_q   <= drop_d;
         halted_q <= halted_d;
      end
   end

   ifu_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Requests are only issued with a free slot, so a response never meets a full buffer.
   push_never_overflows: assert property (@(posedge clk) disable iff (!rst_n)
      push |-> (!fifo_full || pop));

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam int unsigned DEPTH    = 2;
   localparam logic [31:0] EBREAK   = 32'h0010_0073;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid, inst_ready;
   logic [31:0] inst_pc, inst_data;
   logic        halted;

   always #5 clk = ~clk;

   ifu_fetch #(
      .RESET_PC  (RESET_PC),
      .BUF_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_pc        (inst_pc),
      .inst_data      (inst_data),
      .halted         (halted)
   );

   int checks = 0;
   int errors = 0;

   // Memory model: one pending request, latency lat_min..lat_max cycles.
   bit          mem_pend = 0;
   int          mem_wait = 0;
   logic [31:0] mem_addr = '0;
   int          lat_min = 1, lat_max = 1;
   bit          ebreak_en = 0;
   logic [31:0] ebreak_addr = '0;

   // What happened at the clock edge that ended the last cycle() call.
   bit          obs_req, obs_pop, obs_overlap, obs_halted;
   logic [31:0] obs_req_addr, obs_pop_pc, obs_pop_data;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      if (ebreak_en && a == ebreak_addr) return EBREAK;
      w = {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
      if (w == EBREAK) w = w ^ 32'h0000_0100;
      return w;
   endfunction

   // Called at a falling edge: drive one cycle of inputs, record the events the
   // DUT will see at the next rising edge, and return at the following falling edge.
   task automatic cycle(input bit redir, input logic [31:0] tgt, input bit irdy, input bit mrdy);
      redirect_valid = redir;
      redirect_pc    = tgt;
      inst_ready     = irdy;
      imem_req_ready = mrdy;
      if (mem_pend && mem_wait == 0) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(mem_addr);
         mem_pend       = 0;
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
         if (mem_pend) mem_wait--;
      end
      #1;
      obs_req      = imem_req_valid && imem_req_ready;
      obs_req_addr = imem_req_addr;
      obs_overlap  = obs_req && mem_pend;
      if (obs_req) begin
         mem_pend = 1;
         mem_wait = int'($urandom_range(lat_max, lat_min)) - 1;
         mem_addr = imem_req_addr;
      end
      obs_pop      = inst_valid && inst_ready;
      obs_pop_pc   = inst_pc;
      obs_pop_data = inst_data;
      obs_halted   = halted;
      @(negedge clk);
   endtask

   task automatic drive_idle();
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      inst_ready     = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      drive_idle();
      mem_pend  = 0;
      ebreak_en = 0;
      lat_min   = 1;
      lat_max   = 1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive_idle();
      mem_pend = 0;
      #1;
      checks++; if (imem_req_valid !== 1'b0) begin errors++;
         $display("FAIL rst_req_valid: got %b, required 0", imem_req_valid); end
      checks++; if (inst_valid !== 1'b0) begin errors++;
         $display("FAIL rst_inst_valid: got %b, required 0", inst_valid); end
      checks++; if (halted !== 1'b0) begin errors++;
         $display("FAIL rst_halted: got %b, required 0", halted); end
      checks++; if (inst_pc !== 32'h0) begin errors++;
         $display("FAIL rst_inst_pc: got %h, required 0", inst_pc); end
      checks++; if (inst_data !== 32'h0) begin errors++;
         $display("FAIL rst_inst_data: got %h, required 0", inst_data); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (imem_req_valid !== 1'b1) begin errors++;
         $display("FAIL rel_req_valid: got %b, required 1", imem_req_valid); end
      checks++; if (imem_req_addr !== RESET_PC) begin errors++;
         $display("FAIL rel_req_addr: got %h, required %h", imem_req_addr, RESET_PC); end
      @(negedge clk);
   endtask

   task automatic test_sequential();
      logic [31:0] rq[$];
      logic [31:0] pp[$];
      logic [31:0] pd[$];
      logic [31:0] e;
      apply_reset();
      for (int i = 0; i < 40 && (rq.size() < 3 || pp.size() < 3); i++) begin
         cycle(1'b0, '0, 1'b1, 1'b1);
         if (obs_req) rq.push_back(obs_req_addr);
         if (obs_pop) begin pp.push_back(obs_pop_pc); pd.push_back(obs_pop_data); end
      end
      for (int i = 0; i < 3; i++) begin
         e = RESET_PC + 32'(4 * i);
         checks++;
         if (i >= rq.size()) begin errors++;
            $display("FAIL seq_req%0d: no request seen, required %h", i, e); end
         else if (rq[i] !== e) begin errors++;
            $display("FAIL seq_req%0d: got %h, required %h", i, rq[i], e); end
         checks++;
         if (i >= pp.size()) begin errors++;
            $display("FAIL seq_pop%0d: no instruction seen, required pc %h", i, e); end
         else if (pp[i] !== e || pd[i] !== mem_word(e)) begin errors++;
            $display("FAIL seq_pop%0d: got %h/%h, required %h/%h", i, pp[i], pd[i], e,
                     mem_word(e)); end
      end
   endtask

   task automatic test_backpressure();
      int          nreq, n;
      logic [31:0] e;
      apply_reset();
      nreq = 0;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, '0, 1'b0, 1'b1);
         if (obs_req) nreq++;
      end
      checks++; if (nreq != int'(DEPTH)) begin errors++;
         $display("FAIL bp_requests: got %0d, required %0d", nreq, DEPTH); end
      checks++; if (imem_req_valid !== 1'b0) begin errors++;
         $display("FAIL bp_req_stopped: got %b, required 0", imem_req_valid); end
      checks++; if (inst_valid !== 1'b1) begin errors++;
         $display("FAIL bp_inst_valid: got %b, required 1", inst_valid); end
      e = RESET_PC;
      n = 0;
      for (int i = 0; i < 80 && n < int'(DEPTH) + 3; i++) begin
         cycle(1'b0, '0, 1'b1, 1'b1);
         if (obs_pop) begin
            checks++;
            if (obs_pop_pc !== e || obs_pop_data !== mem_word(e)) begin errors++;
               $display("FAIL bp_drain%0d: got %h/%h, required %h/%h", n, obs_pop_pc,
                        obs_pop_data, e, mem_word(e)); end
            e += 32'd4;
            n++;
         end
      end
      checks++; if (n != int'(DEPTH) + 3) begin errors++;
         $display("FAIL bp_drain_count: got %0d, required %0d", n, DEPTH + 3); end
   endtask

   task automatic test_redirect_wait();
      int  nreq;
      bit  leak, got_req, got_pop;
      apply_reset();
      lat_min = 3;
      lat_max = 3;
      nreq = 0;
      for (int i = 0; i < 40 && nreq < 2; i++) begin
         cycle(1'b0, '0, 1'b0, 1'b1);
         if (obs_req) nreq++;
      end
      checks++; if (nreq != 2) begin errors++;
         $display("FAIL rw_setup: got %0d requests, required 2", nreq); end
      // Now waiting on the second response with one entry buffered.
      cycle(1'b1, 32'h8000_0101, 1'b1, 1'b1);
      checks++; if (inst_valid !== 1'b0) begin errors++;
         $display("FAIL rw_flushed: got inst_valid %b, required 0", inst_valid); end
      leak = 0;
      got_req = 0;
      for (int i = 0; i < 40 && !got_req; i++) begin
         cycle(1'b0, '0, 1'b1, 1'b1);
         if (obs_pop) leak = 1;
         if (obs_req) begin
            got_req = 1;
            checks++; if (obs_req_addr !== 32'h8000_0100) begin errors++;
               $display("FAIL rw_req_addr: got %h, required 80000100", obs_req_addr); end
         end
      end
      checks++; if (!got_req || leak) begin errors++;
         $display("FAIL rw_drop: got req_seen %b stale_pop %b, required 1 0", got_req, leak); end
      got_pop = 0;
      for (int i = 0; i < 40 && !got_pop; i++) begin
         cycle(1'b0, '0, 1'b1, 1'b1);
         if (obs_pop) begin
            got_pop = 1;
            checks++;
            if (obs_pop_pc !== 32'h8000_0100 || obs_pop_data !== mem_word(32'h8000_0100)) begin
               errors++;
               $display("FAIL rw_first_pop: got %h/%h, required 80000100/%h", obs_pop_pc,
                        obs_pop_data, mem_word(32'h8000_0100)); end
         end
      end
      checks++; if (!got_pop) begin errors++;
         $display("FAIL rw_pop_timeout: got none, required one pop"); end
   endtask

   task automatic test_ebreak();
      int          npop, later, bad_req;
      bit          seen, halt_at_pop;
      logic [31:0] ebreak_data;
      apply_reset();
      ebreak_en   = 1;
      ebreak_addr = RESET_PC + 32'd12;
      npop = 0; later = 0; bad_req = 0; seen = 0; halt_at_pop = 0; ebreak_data = '0;
      for (int i = 0; i < 60 && !seen; i++) begin
         cycle(1'b0, '0, 1'b1, 1'b1);
         if (obs_req && obs_req_addr == RESET_PC + 32'd16) bad_req++;
         if (obs_pop) begin
            npop++;
            if (obs_pop_pc == ebreak_addr) begin
               seen = 1; ebreak_data = obs_pop_data; halt_at_pop = obs_halted;
            end
         end
      end
      checks++; if (!seen || ebreak_data !== EBREAK) begin errors++;
         $display("FAIL eb_pop: got seen %b data %h, required 1 %h", seen, ebreak_data,
                  EBREAK); end
      checks++; if (halt_at_pop !== 1'b0) begin errors++;
         $display("FAIL eb_early_halt: got %b, required 0", halt_at_pop); end
      checks++; if (halted !== 1'b1) begin errors++;
         $display("FAIL eb_halted: got %b, required 1", halted); end
      checks++; if (npop != 4) begin errors++;
         $display("FAIL eb_pops: got %0d, required 4", npop); end
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, '0, 1'b1, 1'b1);
         if (obs_req) later++;
      end
      checks++; if (later + bad_req != 0) begin errors++;
         $display("FAIL eb_no_fetch: got %0d requests, required 0", later + bad_req); end
      checks++; if (halted !== 1'b1) begin errors++;
         $display("FAIL eb_halt_hold: got %b, required 1", halted); end
   endtask

   task automatic test_halt_redirect();
      bit got_req, got_pop;
      ebreak_en = 0;
      cycle(1'b1, RESET_PC, 1'b1, 1'b1);
      checks++; if (halted !== 1'b0) begin errors++;
         $display("FAIL hr_halted: got %b, required 0", halted); end
      got_req = 0; got_pop = 0;
      for (int i = 0; i < 40 && !got_pop; i++) begin
         cycle(1'b0, '0, 1'b1, 1'b1);
         if (obs_req && !got_req) begin
            got_req = 1;
            checks++; if (obs_req_addr !== RESET_PC) begin errors++;
               $display("FAIL hr_req_addr: got %h, required %h", obs_req_addr, RESET_PC); end
         end
         if (obs_pop) begin
            got_pop = 1;
            checks++; if (obs_pop_pc !== RESET_PC || obs_pop_data !== mem_word(RESET_PC)) begin
               errors++;
               $display("FAIL hr_pop: got %h/%h, required %h/%h", obs_pop_pc, obs_pop_data,
                        RESET_PC, mem_word(RESET_PC)); end
         end
      end
      checks++; if (!got_pop) begin errors++;
         $display("FAIL hr_timeout: got none, required fetch to resume"); end
   endtask

   task automatic test_reset_wait();
      bit got_req, got_pop;
      int stray;
      apply_reset();
      lat_min = 3;
      lat_max = 3;
      got_req = 0;
      for (int i = 0; i < 20 && !got_req; i++) begin
         cycle(1'b0, '0, 1'b1, 1'b1);
         got_req = obs_req;
      end
      // Waiting on memory; the response is still owed when reset hits.
      rst_n = 1'b0;
      #1;
      checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || halted !== 1'b0 ||
                    inst_pc !== 32'h0 || inst_data !== 32'h0) begin errors++;
         $display("FAIL rwr_outputs: got req %b inst %b halt %b pc %h data %h, required 0 0 0 0 0",
                  imem_req_valid, inst_valid, halted, inst_pc, inst_data); end
      @(negedge clk);
      rst_n = 1'b1;
      stray = 0;
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, '0, 1'b1, 1'b0);
         if (obs_pop) stray++;
      end
      checks++; if (stray != 0 || mem_pend) begin errors++;
         $display("FAIL rwr_late_rsp: got %0d buffered (pending %b), required 0", stray,
                  mem_pend); end
      got_req = 0; got_pop = 0;
      for (int i = 0; i < 40 && !got_pop; i++) begin
         cycle(1'b0, '0, 1'b1, 1'b1);
         if (obs_req && !got_req) begin
            got_req = 1;
            checks++; if (obs_req_addr !== RESET_PC) begin errors++;
               $display("FAIL rwr_req_addr: got %h, required %h", obs_req_addr, RESET_PC); end
         end
         if (obs_pop) begin
            got_pop = 1;
            checks++; if (obs_pop_pc !== RESET_PC) begin errors++;
               $display("FAIL rwr_pop: got %h, required %h", obs_pop_pc, RESET_PC); end
         end
      end
      checks++; if (!got_pop) begin errors++;
         $display("FAIL rwr_timeout: got none, required a fetch after reset"); end
   endtask

   // Program-order model: within each redirect epoch requests and delivered
   // instructions both walk target, target+4, ...; a redirect starts a new epoch.
   task automatic test_random();
      logic [31:0] exp_req, exp_pop, tgt;
      bit          redir, last_redir, irdy, mrdy;
      apply_reset();
      lat_min = 1;
      lat_max = 3;
      exp_req = RESET_PC;
      exp_pop = RESET_PC;
      last_redir = 0;
      for (int i = 0; i < 3000; i++) begin
         if (last_redir) begin
            checks++; if (inst_valid !== 1'b0) begin errors++;
               $display("FAIL rnd_flush@%0d: got inst_valid %b, required 0", i, inst_valid); end
         end
         redir = !last_redir && ($urandom_range(99) < 3);
         tgt   = RESET_PC + 32'($urandom_range(255));
         irdy  = ($urandom_range(99) < 70);
         mrdy  = ($urandom_range(99) < 70);
         cycle(redir, tgt, irdy, mrdy);
         if (obs_req) begin
            checks++; if (obs_req_addr !== exp_req || obs_overlap) begin errors++;
               $display("FAIL rnd_req@%0d: got %h (overlap %b), required %h (overlap 0)", i,
                        obs_req_addr, obs_overlap, exp_req); end
            exp_req += 32'd4;
         end
         if (obs_pop) begin
            checks++; if (obs_pop_pc !== exp_pop || obs_pop_data !== mem_word(exp_pop)) begin
               errors++;
               $display("FAIL rnd_pop@%0d: got %h/%h, required %h/%h", i, obs_pop_pc,
                        obs_pop_data, exp_pop, mem_word(exp_pop)); end
            exp_pop += 32'd4;
         end
         if (redir) begin
            exp_req = tgt & ~32'h3;
            exp_pop = exp_req;
         end
         last_redir = redir;
      end
   endtask

   initial begin
      drive_idle();
      @(negedge clk);
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect_wait();
      test_ebreak();
      test_halt_redirect();
      test_reset_wait();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
